// File: rtl/uart_load_ctrl.sv
// rtl/uart_load_ctrl.sv - UART receive framing, word packing, RAM write sequencing and tx arbitration
module uart_load_ctrl #(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15,
    parameter int          ERR_W     = 8
) (
    input  logic              clkout,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_dataerr,
    input  logic              rx_frameerr,
    input  logic              buf_release,
    input  logic              tx_idle,
    output logic [31:0]       ram_wrdata,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic              ram_wren,
    output logic              buf_ready,
    output logic [7:0]        tx_data,
    output logic              tx_wrsig,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FULL = 2'd2} state_t;

    state_t              state_q, state_d, cur_state;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [31:0]         word_q, word_d;
    logic                ram_wren_q, ram_wren_d;
    logic [31:0]         ram_wrdata_q, ram_wrdata_d;
    logic [ADDR_W-1:0]   ram_wraddr_q, ram_wraddr_d;
    logic                buf_ready_q, buf_ready_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                slot_full_q, slot_full_d;
    logic [7:0]          slot_data_q, slot_data_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_wrsig_q, tx_wrsig_d;

    logic                good_byte, bad_byte, release_now, last_written;
    logic                echo_req, status_req, slot_after_pop;
    logic [7:0]          status_byte;

    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            widx_q       <= '0;
            word_q       <= 32'd0;
            ram_wren_q   <= 1'b0;
            ram_wrdata_q <= 32'd0;
            ram_wraddr_q <= '0;
            buf_ready_q  <= 1'b0;
            err_q        <= '0;
            slot_full_q  <= 1'b0;
            slot_data_q  <= 8'd0;
            tx_data_q    <= 8'd0;
            tx_wrsig_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            widx_q       <= widx_d;
            word_q       <= word_d;
            ram_wren_q   <= ram_wren_d;
            ram_wrdata_q <= ram_wrdata_d;
            ram_wraddr_q <= ram_wraddr_d;
            buf_ready_q  <= buf_ready_d;
            err_q        <= err_d;
            slot_full_q  <= slot_full_d;
            slot_data_q  <= slot_data_d;
            tx_data_q    <= tx_data_d;
            tx_wrsig_q   <= tx_wrsig_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        widx_d       = widx_q;
        word_d       = word_q;
        ram_wren_d   = 1'b0;
        ram_wrdata_d = ram_wrdata_q;
        ram_wraddr_d = ram_wraddr_q;
        buf_ready_d  = buf_ready_q;
        err_d        = err_q;
        slot_full_d  = slot_full_q;
        slot_data_d  = slot_data_q;
        tx_data_d    = tx_data_q;
        tx_wrsig_d   = 1'b0;
        echo_req     = 1'b0;
        status_req   = 1'b0;
        status_byte  = NAK_BYTE;

        good_byte    = rx_valid && !rx_dataerr && !rx_frameerr;
        bad_byte     = rx_valid && (rx_dataerr || rx_frameerr);
        release_now  = (state_q == S_FULL) && buf_release;
        last_written = ram_wren_q && (ram_wraddr_q == {ADDR_W{1'b1}});
        // A release takes effect before a byte arriving in the same cycle.
        cur_state    = release_now ? S_IDLE : state_q;

        if (release_now) begin
            buf_ready_d = 1'b0;
            state_d     = S_IDLE;
        end

        if (bad_byte) begin
            err_d      = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + 1'b1;
            status_req = 1'b1;
            if (cur_state == S_LOAD) begin
                state_d    = S_IDLE;
                byte_cnt_d = 2'd0;
                widx_d     = '0;
            end
        end else if (good_byte) begin
            case (cur_state)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d    = S_LOAD;
                        byte_cnt_d = 2'd0;
                        widx_d     = '0;
                        echo_req   = 1'b1;
                    end
                end
                S_LOAD: begin
                    echo_req   = 1'b1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = rx_data;
                        2'd1:    word_d[15:8]  = rx_data;
                        2'd2:    word_d[23:16] = rx_data;
                        default: word_d[31:24] = rx_data;
                    endcase
                    if (byte_cnt_q == 2'd3) begin
                        ram_wren_d   = 1'b1;
                        ram_wrdata_d = {rx_data, word_q[23:0]};
                        ram_wraddr_d = widx_q;
                        widx_d       = widx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Buffer completion is acted on the cycle after the final write strobe.
        if (last_written) begin
            state_d     = S_FULL;
            buf_ready_d = 1'b1;
            status_req  = 1'b1;
            status_byte = ACK_BYTE;
        end

        slot_after_pop = slot_full_q;
        if (slot_full_q && tx_idle && !tx_wrsig_q) begin
            tx_wrsig_d     = 1'b1;
            tx_data_d      = slot_data_q;
            slot_after_pop = 1'b0;
        end
        slot_full_d = slot_after_pop;
        if (status_req) begin
            slot_full_d = 1'b1;
            slot_data_d = status_byte;
        end else if (echo_req && !slot_after_pop) begin
            slot_full_d = 1'b1;
            slot_data_d = rx_data;
        end
    end

    assign ram_wrdata = ram_wrdata_q;
    assign ram_wraddr = ram_wraddr_q;
    assign ram_wren   = ram_wren_q;
    assign buf_ready  = buf_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_wrsig   = tx_wrsig_q;
    assign err_count  = err_q;
    assign state      = state_q;

endmodule
